// File: rtl/div_issue_if.sv
// Bundles the EX-stage handshake and the divider-side port of div_issue.
// slave: the issue block. master: the EX stage and divider around it.
interface div_issue_if;
  logic        div_req_i;
  logic        div_signed_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic        flush_i;
  logic        stall_hold_i;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        div_start_o;
  logic        div_signed_o;
  logic [31:0] div_opdata1_o;
  logic [31:0] div_opdata2_o;
  logic        div_annul_o;
  logic        stallreq_o;
  logic        whilo_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        timeout_o;

  modport slave (
    input  div_req_i, div_signed_i, reg1_i, reg2_i, flush_i, stall_hold_i,
           div_result_i, div_ready_i,
    output div_start_o, div_signed_o, div_opdata1_o, div_opdata2_o,
           div_annul_o, stallreq_o, whilo_o, hi_o, lo_o, timeout_o
  );

  modport master (
    output div_req_i, div_signed_i, reg1_i, reg2_i, flush_i, stall_hold_i,
           div_result_i, div_ready_i,
    input  div_start_o, div_signed_o, div_opdata1_o, div_opdata2_o,
           div_annul_o, stallreq_o, whilo_o, hi_o, lo_o, timeout_o
  );
endinterface

// File: rtl/div_issue.sv
// Issues one DIV/DIVU from EX to a multi-cycle divider, stalls EX until the
// result lands in HI/LO, and aborts the operation on flush or watchdog expiry.
module div_issue #(
  parameter int WDOG_LIMIT = 48
) (
  input  logic        clk,
  input  logic        rst,
  div_issue_if.slave  bus
);

  localparam int CNT_W = $clog2(WDOG_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WDOG_LIMIT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q;
  logic             start_q;
  logic             signed_q;
  logic [31:0]      op1_q;
  logic [31:0]      op2_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic             timeout_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             wdog_hit;
  logic             stallreq;
  logic             annul;
  logic             whilo;

  assign cnt_d    = cnt_q + CNT_W'(1);
  // A ready in the last watchdog cycle still wins over the abort.
  assign wdog_hit = (state_q == BUSY) && !bus.div_ready_i && (cnt_q == CNT_LAST);

  always_comb begin
    stallreq = 1'b0;
    annul    = 1'b0;
    whilo    = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE:    stallreq = bus.div_req_i && !bus.flush_i;
        BUSY: begin
          stallreq = 1'b1;
          annul    = bus.flush_i || wdog_hit;
        end
        DONE:    whilo = !bus.flush_i;
        default: stallreq = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      signed_q  <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.div_req_i && !bus.flush_i) begin
            op1_q    <= bus.reg1_i;
            op2_q    <= bus.reg2_i;
            signed_q <= bus.div_signed_i;
            start_q  <= 1'b1;
            cnt_q    <= '0;
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          if (bus.flush_i) begin
            start_q <= 1'b0;
            state_q <= IDLE;
          end else if (bus.div_ready_i) begin
            hi_q    <= bus.div_result_i[63:32];
            lo_q    <= bus.div_result_i[31:0];
            start_q <= 1'b0;
            state_q <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            timeout_q <= 1'b1;
            start_q   <= 1'b0;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE: begin
          // Always leave through IDLE so the retired instruction cannot re-issue.
          if (!(bus.stall_hold_i && !bus.flush_i)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.div_start_o   = start_q;
  assign bus.div_signed_o  = signed_q;
  assign bus.div_opdata1_o = op1_q;
  assign bus.div_opdata2_o = op2_q;
  assign bus.div_annul_o   = annul;
  assign bus.stallreq_o    = stallreq;
  assign bus.whilo_o       = whilo;
  assign bus.hi_o          = hi_q;
  assign bus.lo_o          = lo_q;
  assign bus.timeout_o     = timeout_q;

endmodule

// File: tb/tb_div_issue.sv
// Bench for div_issue: directed scenarios plus randomized traffic, all outputs
// compared every cycle against a behavioural model of the issue protocol.
module tb_div_issue;

  localparam int WD = 48;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_issue_if ifc ();
  div_issue #(.WDOG_LIMIT(WD)) dut (.clk(clk), .rst(rst), .bus(ifc));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk32(nm, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Reference divider arithmetic: {remainder, quotient}, truncating toward zero.
  function automatic logic [63:0] div_ref(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua, ub, q, r;
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    if (!s) return {a % b, a / b};
    if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
    ua = a[31] ? -a : a;
    ub = b[31] ? -b : b;
    q = ua / ub;
    r = ua % ub;
    if (a[31] ^ b[31]) q = -q;
    if (a[31]) r = -r;
    return {r, q};
  endfunction

  // Next-cycle stimulus, applied just after each rising edge
  logic        n_rst, n_req, n_sgn, n_flush, n_hold;
  logic [31:0] n_r1, n_r2;
  int          lat_next, lat, dcnt;
  bit          dbusy, dsent;

  task automatic step();
    @(posedge clk);
    #1;
    rst              = n_rst;
    ifc.div_req_i    = n_req;
    ifc.div_signed_i = n_sgn;
    ifc.reg1_i       = n_r1;
    ifc.reg2_i       = n_r2;
    ifc.flush_i      = n_flush;
    ifc.stall_hold_i = n_hold;
    // Divider: counts cycles of div_start_o high, answers once after lat cycles
    if (ifc.div_start_o) begin
      if (!dbusy) begin
        dbusy = 1'b1;
        dcnt  = 0;
        lat   = lat_next;
      end
      dcnt++;
    end else begin
      dbusy = 1'b0;
      dsent = 1'b0;
    end
    ifc.div_ready_i  = 1'b0;
    ifc.div_result_i = {$urandom, $urandom};
    if (dbusy && !dsent && dcnt >= lat) begin
      ifc.div_ready_i  = 1'b1;
      ifc.div_result_i = div_ref(ifc.div_signed_o, ifc.div_opdata1_o, ifc.div_opdata2_o);
      dsent = 1'b1;
    end
    @(negedge clk);
    #1;
  endtask

  // Behavioural model: one in-flight operation with a phase and an age
  localparam int P_IDLE = 0, P_BUSY = 1, P_DONE = 2;
  int          m_ph = P_IDLE, m_age = 0;
  logic        m_start = 0, m_sgn = 0, m_to = 0;
  logic [31:0] m_op1 = 0, m_op2 = 0, m_hi = 0, m_lo = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_ph = P_IDLE; m_age = 0; m_start = 0; m_sgn = 0; m_to = 0;
      m_op1 = 0; m_op2 = 0; m_hi = 0; m_lo = 0;
    end else begin
      m_to = 0;
      if (m_ph == P_IDLE) begin
        if (ifc.div_req_i && !ifc.flush_i) begin
          m_op1 = ifc.reg1_i; m_op2 = ifc.reg2_i; m_sgn = ifc.div_signed_i;
          m_start = 1; m_age = 0; m_ph = P_BUSY;
        end
      end else if (m_ph == P_BUSY) begin
        if (ifc.flush_i) begin
          m_start = 0; m_ph = P_IDLE;
        end else if (ifc.div_ready_i) begin
          m_hi = ifc.div_result_i[63:32]; m_lo = ifc.div_result_i[31:0];
          m_start = 0; m_ph = P_DONE;
        end else if (m_age == WD - 1) begin
          m_to = 1; m_start = 0; m_ph = P_IDLE;
        end else begin
          m_age++;
        end
      end else begin
        if (!(ifc.stall_hold_i && !ifc.flush_i)) m_ph = P_IDLE;
      end
    end
  end

  always @(negedge clk) begin
    logic e_stall, e_annul, e_whilo;
    if (chk_en) begin
      e_stall = !rst && ((m_ph == P_IDLE && ifc.div_req_i && !ifc.flush_i) || m_ph == P_BUSY);
      e_annul = !rst && m_ph == P_BUSY &&
                (ifc.flush_i || (!ifc.div_ready_i && m_age == WD - 1));
      e_whilo = !rst && m_ph == P_DONE && !ifc.flush_i;
      chk1("stallreq", ifc.stallreq_o, e_stall);
      chk1("annul", ifc.div_annul_o, e_annul);
      chk1("whilo", ifc.whilo_o, e_whilo);
      chk1("start", ifc.div_start_o, m_start);
      chk1("signed", ifc.div_signed_o, m_sgn);
      chk32("opdata1", ifc.div_opdata1_o, m_op1);
      chk32("opdata2", ifc.div_opdata2_o, m_op2);
      chk32("hi", ifc.hi_o, m_hi);
      chk32("lo", ifc.lo_o, m_lo);
      chk1("timeout", ifc.timeout_o, m_to);
    end
  end

  initial begin
    int wcyc, wcnt, rises;
    bit got, early, prev;

    rst = 1'b1;
    ifc.div_req_i = 0; ifc.div_signed_i = 0; ifc.reg1_i = 0; ifc.reg2_i = 0;
    ifc.flush_i = 0; ifc.stall_hold_i = 0; ifc.div_result_i = 0; ifc.div_ready_i = 0;
    n_rst = 1; n_req = 0; n_sgn = 0; n_r1 = 0; n_r2 = 0; n_flush = 0; n_hold = 0;
    lat_next = 34; lat = 34; dcnt = 0; dbusy = 0; dsent = 0;
    step(); step();
    n_rst = 0;
    step();
    chk_en = 1'b1;
    chk1("rst_start", ifc.div_start_o, 1'b0);
    chk1("rst_signed", ifc.div_signed_o, 1'b0);
    chk32("rst_op1", ifc.div_opdata1_o, 32'd0);
    chk32("rst_hi", ifc.hi_o, 32'd0);
    chk32("rst_lo", ifc.lo_o, 32'd0);
    chk1("rst_stall", ifc.stallreq_o, 1'b0);

    // Signed -7 / 2 with a 34-cycle divider
    n_req = 1; n_sgn = 1; n_r1 = 32'hFFFFFFF9; n_r2 = 32'd2; lat_next = 34;
    step();
    chk1("t1_stall_c0", ifc.stallreq_o, 1'b1);
    chk1("t1_start_c0", ifc.div_start_o, 1'b0);
    got = 0; wcyc = -1;
    for (int i = 1; i <= 100 && !got; i++) begin
      step();
      if (i == 1) chk1("t1_start_c1", ifc.div_start_o, 1'b1);
      if (ifc.whilo_o) begin got = 1; wcyc = i; end
    end
    chk1("t1_whilo_seen", got, 1'b1);
    chki("t1_whilo_cycle", wcyc, 35);
    chk32("t1_hi", ifc.hi_o, 32'hFFFFFFFF);
    chk32("t1_lo", ifc.lo_o, 32'hFFFFFFFD);
    chk1("t1_stall_done", ifc.stallreq_o, 1'b0);
    n_req = 0;
    step();
    chk1("t1_whilo_once", ifc.whilo_o, 1'b0);

    // Unsigned 100 / 7
    n_req = 1; n_sgn = 0; n_r1 = 32'd100; n_r2 = 32'd7; lat_next = 6;
    step();
    got = 0;
    for (int i = 1; i <= 100 && !got; i++) begin
      step();
      if (ifc.whilo_o) got = 1;
      else begin
        chk32("t2_op1", ifc.div_opdata1_o, 32'd100);
        chk32("t2_op2", ifc.div_opdata2_o, 32'd7);
        chk1("t2_signed", ifc.div_signed_o, 1'b0);
      end
    end
    chk1("t2_whilo_seen", got, 1'b1);
    chk32("t2_hi", ifc.hi_o, 32'd2);
    chk32("t2_lo", ifc.lo_o, 32'd14);
    n_req = 0;
    step();

    // Flush in BUSY cycle 10
    n_req = 1; n_sgn = 1; n_r1 = 32'd1234; n_r2 = 32'd5; lat_next = 34;
    step();
    for (int i = 1; i <= 9; i++) step();
    n_flush = 1;
    step();
    chk1("t3_annul", ifc.div_annul_o, 1'b1);
    chk1("t3_whilo", ifc.whilo_o, 1'b0);
    n_flush = 0; n_req = 0;
    step();
    chk1("t3_idle_stall", ifc.stallreq_o, 1'b0);
    chk1("t3_idle_start", ifc.div_start_o, 1'b0);
    chk32("t3_hi_kept", ifc.hi_o, 32'd2);
    chk32("t3_lo_kept", ifc.lo_o, 32'd14);

    // Hold in DONE for three cycles with the request still present
    n_req = 1; n_sgn = 0; n_r1 = 32'd50; n_r2 = 32'd3; n_hold = 1; lat_next = 3;
    step();
    got = 0;
    for (int i = 1; i <= 100 && !got; i++) begin
      step();
      if (ifc.whilo_o) got = 1;
    end
    chk1("t4_whilo_seen", got, 1'b1);
    wcnt = 1; rises = 0; prev = ifc.div_start_o;
    for (int k = 1; k <= 5; k++) begin
      n_hold = (k <= 2);
      n_req  = (k <= 3);
      step();
      if (ifc.whilo_o) wcnt++;
      if (ifc.div_start_o && !prev) rises++;
      prev = ifc.div_start_o;
    end
    chki("t4_whilo_cycles", wcnt, 4);
    chki("t4_start_rises", rises, 0);
    chk32("t4_hi", ifc.hi_o, 32'd2);
    chk32("t4_lo", ifc.lo_o, 32'd16);
    n_hold = 0;

    // Watchdog: divider never answers
    n_req = 1; n_sgn = 0; n_r1 = 32'd9; n_r2 = 32'd3; lat_next = 1000;
    step();
    n_req = 0;
    early = 0;
    for (int i = 1; i <= WD - 1; i++) begin
      step();
      if (ifc.div_annul_o) early = 1;
    end
    chk1("t5_no_early_annul", early, 1'b0);
    step();
    chk1("t5_annul", ifc.div_annul_o, 1'b1);
    chk1("t5_no_whilo", ifc.whilo_o, 1'b0);
    step();
    chk1("t5_timeout", ifc.timeout_o, 1'b1);
    chk1("t5_start_low", ifc.div_start_o, 1'b0);
    chk1("t5_idle_stall", ifc.stallreq_o, 1'b0);
    chk32("t5_hi_kept", ifc.hi_o, 32'd2);
    step();
    chk1("t5_timeout_pulse", ifc.timeout_o, 1'b0);

    // Reset in BUSY cycle 20
    n_req = 1; n_sgn = 1; n_r1 = 32'd77; n_r2 = 32'd4; lat_next = 34;
    step();
    n_req = 0;
    for (int i = 1; i <= 19; i++) step();
    n_rst = 1;
    step();
    chk1("t6_rst_stall", ifc.stallreq_o, 1'b0);
    chk1("t6_rst_annul", ifc.div_annul_o, 1'b0);
    n_rst = 0;
    step();
    chk1("t6_start", ifc.div_start_o, 1'b0);
    chk1("t6_signed", ifc.div_signed_o, 1'b0);
    chk32("t6_op1", ifc.div_opdata1_o, 32'd0);
    chk32("t6_op2", ifc.div_opdata2_o, 32'd0);
    chk32("t6_hi", ifc.hi_o, 32'd0);
    chk32("t6_lo", ifc.lo_o, 32'd0);
    chk1("t6_timeout", ifc.timeout_o, 1'b0);
    chk1("t6_stall", ifc.stallreq_o, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      n_rst   = ($urandom_range(0, 599) == 0);
      n_req   = ($urandom_range(0, 2) != 0);
      n_sgn   = $urandom_range(0, 1) != 0;
      n_flush = ($urandom_range(0, 24) == 0);
      n_hold  = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 5))
        0: n_r1 = 32'd0;
        1: n_r1 = 32'h80000000;
        2: n_r1 = $urandom_range(0, 200);
        default: n_r1 = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: n_r2 = 32'd0;
        1: n_r2 = 32'hFFFFFFFF;
        2: n_r2 = $urandom_range(1, 9);
        default: n_r2 = $urandom;
      endcase
      lat_next = ($urandom_range(0, 9) == 0) ? $urandom_range(40, 60) : $urandom_range(1, 8);
      step();
    end

    n_rst = 0; n_req = 0; n_flush = 0; n_hold = 0;
    step(); step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_issue.md
DIV_ISSUE -- requirements
Module: div_issue

Interface
REQ-001 clk  input  1  rising-edge clock.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 div_req_i  input  1  EX stage holds a DIV/DIVU instruction.
REQ-004 div_signed_i  input  1  1 = DIV (signed), 0 = DIVU.
REQ-005 reg1_i, reg2_i  input  32 each  dividend, divisor from EX.
REQ-006 flush_i  input  1  pipeline flush/exception; kills the EX instruction.
REQ-007 stall_hold_i  input  1  a later stage is stalling; EX cannot retire this cycle.
REQ-008 div_result_i  input  64  divider result: {remainder, quotient}.
REQ-009 div_ready_i  input  1  divider result valid.
REQ-010 div_start_o  output  1  divider start, registered.
REQ-011 div_signed_o  output  1  latched signedness, registered.
REQ-012 div_opdata1_o, div_opdata2_o  output  32 each  latched operands, registered.
REQ-013 div_annul_o  output  1  divider cancel, combinational.
REQ-014 stallreq_o  output  1  EX stall request, combinational.
REQ-015 whilo_o  output  1  HI/LO write enable, combinational.
REQ-016 hi_o, lo_o  output  32 each  captured remainder and quotient, registered.
REQ-017 timeout_o  output  1  one-cycle pulse when the watchdog expires, registered.
REQ-018 Parameter WDOG_LIMIT, default 48: the maximum number of BUSY cycles before an abort.

Function
REQ-019 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-020 IDLE: stallreq_o SHALL equal div_req_i & ~flush_i.
REQ-021 IDLE: on an edge with div_req_i=1 and flush_i=0, the block SHALL:
- latch reg1_i/reg2_i/div_signed_i into the div_* outputs;
- set div_start_o<=1 and clear the watchdog count;
- move to BUSY.
REQ-022 BUSY: stallreq_o=1, and div_start_o and the operand outputs SHALL be held stable.
REQ-023 BUSY: the watchdog count SHALL increment each cycle.
REQ-024 BUSY with flush_i=1 SHALL take priority over ready and watchdog:
- div_annul_o=1 in that same cycle;
- next edge: div_start_o<=0, state IDLE, hi_o/lo_o unchanged.
REQ-025 BUSY with div_ready_i=1 and flush_i=0: next edge SHALL capture hi_o<=div_result_i[63:32] and lo_o<=div_result_i[31:0], set div_start_o<=0, and move to DONE.
REQ-026 BUSY when the count reaches WDOG_LIMIT-1 without ready or flush:
- div_annul_o=1 in that cycle;
- next edge: timeout_o<=1 for one cycle, div_start_o<=0, state IDLE;
- whilo_o is never asserted for the aborted instruction.
REQ-027 DONE: stallreq_o=0, div_start_o=0, and whilo_o SHALL equal ~flush_i.
REQ-028 DONE exit: if stall_hold_i=1 and flush_i=0, the FSM SHALL stay in DONE with hi_o/lo_o stable; otherwise it SHALL go to IDLE, so the same instruction never re-issues.
REQ-029 div_annul_o SHALL be 0 outside the BUSY cases above, and whilo_o SHALL be 0 outside DONE.
REQ-030 No arithmetic on the result SHALL be done here: sign correction belongs to the divider, and divide-by-zero is passed through as returned.
REQ-031 Latency: a request in cycle 0 raises div_start_o in cycle 1; whilo_o is asserted in the cycle after div_ready_i is first seen.
REQ-032 A new request SHALL be accepted no earlier than the first IDLE cycle after DONE, so div_start_o always sees at least one low cycle between operations.

Reset
REQ-033 When rst=1 at an edge, from any state including mid-operation:
- state becomes IDLE;
- div_start_o, div_signed_o, timeout_o = 0;
- div_opdata1_o, div_opdata2_o, hi_o, lo_o = 0;
- watchdog count = 0.
REQ-034 While rst=1, the combinational outputs stallreq_o, whilo_o and div_annul_o SHALL be 0.

Verification
REQ-035 Signed: DIV with reg1=0xFFFFFFF9 (-7), reg2=2, divider model responding 0xFFFFFFFF_FFFFFFFD after 34 cycles:
- div_start_o high from cycle 1;
- stallreq_o high until DONE;
- whilo_o one cycle with hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFD.
REQ-036 Unsigned: DIVU 100/7 -> hi_o=2, lo_o=14, div_signed_o=0, operands stable throughout BUSY.
REQ-037 Flush: flush_i=1 in BUSY cycle 10:
- div_annul_o=1 that cycle;
- IDLE next cycle;
- whilo_o never asserted, hi_o/lo_o unchanged.
REQ-038 Hold: stall_hold_i=1 for 3 cycles in DONE with div_req_i still 1:
- whilo_o high for 4 cycles;
- no second div_start_o rising edge.
REQ-039 Watchdog: div_ready_i tied 0:
- div_annul_o=1 in BUSY cycle 48;
- timeout_o pulse in the next cycle, then IDLE.
REQ-040 Reset: rst=1 in BUSY cycle 20 -> all registered outputs 0 next cycle, and stallreq_o=0.
